// File: rtl/reg_seq_ctrl.sv
// Multi-cycle sequencer for a 4 x 8-bit register file: fetch, decode, execute, write back.
// It is the only master of the register-file write port; one write-back per ALU instruction.
module reg_seq_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            stop,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [7:0]      instr_data,
  output logic [1:0]      rf_rs,
  output logic [1:0]      rf_rt,
  input  logic [7:0]      rf_rdata1,
  input  logic [7:0]      rf_rdata2,
  output logic            rf_we,
  output logic [1:0]      rf_wr,
  output logic [7:0]      rf_wdata,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic            stop_q, stop_d;
  logic            rf_we_q, rf_we_d;
  logic [1:0]      rf_wr_q, rf_wr_d;
  logic [7:0]      rf_wdata_q, rf_wdata_d;
  logic            done_q, done_d;

  logic            stop_pend;
  logic [7:0]      imm_ext;
  logic [PC_W-1:0] jmp_off;

  assign stop_pend = stop_q | stop;
  assign imm_ext   = {{6{ir_q[1]}}, ir_q[1:0]};
  assign jmp_off   = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    stop_d     = stop_q;
    rf_we_d    = 1'b0;
    rf_wr_d    = rf_wr_q;
    rf_wdata_d = rf_wdata_q;
    done_d     = 1'b0;

    // Stop is sticky while running and only acted on at instruction boundaries.
    if (state_q != S_IDLE) stop_d = stop_pend;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rdata1;
        b_d     = rf_rdata2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (ir_q[7:6])
          2'b00: begin
            rf_we_d    = 1'b1;
            rf_wr_d    = ir_q[1:0];
            rf_wdata_d = a_q + b_q;
            state_d    = S_WB;
          end
          2'b01: begin
            rf_we_d    = 1'b1;
            rf_wr_d    = ir_q[3:2];
            rf_wdata_d = a_q + imm_ext;
            state_d    = S_WB;
          end
          2'b10: begin
            rf_we_d    = 1'b1;
            rf_wr_d    = ir_q[1:0];
            rf_wdata_d = a_q - b_q;
            state_d    = S_WB;
          end
          default: begin
            // Offset 0 is a halt; pc is left pointing past it.
            if (ir_q[5:0] == 6'd0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end else begin
              pc_d = pc_q + jmp_off;
              if (stop_pend) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                stop_d  = 1'b0;
              end else begin
                state_d = S_FETCH;
              end
            end
          end
        endcase
      end
      S_WB: begin
        if (stop_pend) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 8'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      stop_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wr_q    <= 2'd0;
      rf_wdata_q <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      stop_q     <= stop_d;
      rf_we_q    <= rf_we_d;
      rf_wr_q    <= rf_wr_d;
      rf_wdata_q <= rf_wdata_d;
      done_q     <= done_d;
    end
  end

  // A clear arriving during WB suppresses that write at the same edge.
  assign rf_we      = rf_we_q & ~clr;
  assign rf_wr      = rf_wr_q;
  assign rf_wdata   = rf_wdata_q;
  assign instr_req  = (state_q == S_FETCH);
  assign instr_addr = pc_q;
  assign rf_rs      = ir_q[5:4];
  assign rf_rt      = ir_q[3:2];
  assign pc         = pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/reg_seq_ctrl.md
Name: reg_seq_ctrl

Overview:
Multi-cycle control sequencer for the 4 x 8-bit register file.
- Fetches 8-bit instructions over a req/valid handshake, decodes them and drives the register file read and write ports.
- Computes the ALU result internally and issues one write-back per instruction.
- Sits between the instruction ROM and the register file; it is the only master of the register-file write port.

Parameters:
PC_W, 8, program counter and instruction address width
RESET_PC, 0, program counter value after reset

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  reset, synchronous, active-high
start  in  1  begin execution from current pc; honoured only in IDLE
stop  in  1  request halt after the current instruction completes
instr_req  out  1  fetch request, high throughout FETCH
instr_addr  out  PC_W  fetch address (= pc)
instr_valid  in  1  instruction data valid
instr_data  in  8  instruction; captured when instr_req & instr_valid
rf_rs  out  2  register file read select 1
rf_rt  out  2  register file read select 2
rf_rdata1  in  8  register file read data 1 (combinational from rf_rs)
rf_rdata2  in  8  register file read data 2 (combinational from rf_rt)
rf_we  out  1  register file write enable
rf_wr  out  2  register file write select
rf_wdata  out  8  register file write data
pc  out  PC_W  current program counter
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
Instruction format, ir[7:0]:
- op = ir[7:6]
- rs = ir[5:4]
- rt = ir[3:2]
- rd/imm2 = ir[1:0]
- jump offset = ir[5:0]

Opcodes:
- 00 add: R[rd] = R[rs] + R[rt]
- 01 addi: R[rt] = R[rs] + sext(imm2), imm2 range -2..+1
- 10 sub: R[rd] = R[rs] - R[rt]
- 11 jmp: pc = pc + sext(ir[5:0]), relative to the already-incremented pc; offset 0 = halt

Arithmetic:
- All arithmetic is 8-bit modulo 256; no flags.
- pc arithmetic is modulo 2^PC_W, so pc wraps 255->0.

States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE: busy=0, instr_req=0, rf_we=0. start=1 -> FETCH next cycle.
- FETCH: instr_req=1, instr_addr=pc. Stays in FETCH until instr_valid=1. On that edge: ir<=instr_data, pc<=pc+1, -> DECODE. instr_valid outside FETCH is ignored.
- DECODE: rf_rs=ir[5:4], rf_rt=ir[3:2]. Latch A<=rf_rdata1, B<=rf_rdata2. -> EXEC.
- EXEC:
  - add/addi/sub: result<=computed value. -> WB.
  - jmp, offset != 0: pc<=pc+sext(offset). -> FETCH, or IDLE if stop is pending.
  - jmp, offset = 0: pc unchanged (points past the halt). -> IDLE, done=1.
- WB: rf_we=1 for exactly one cycle, rf_wr = rd (add/sub) or rt (addi), rf_wdata=result. -> FETCH, or IDLE with done=1 if stop is pending.

Registered outputs:
- rf_we, rf_wr, rf_wdata and done are registered: they are valid during the WB cycle, and done is asserted during the first IDLE cycle.
- rf_rs and rf_rt are driven from ir in every state (0 when ir=0).

Stop handling:
- stop is a sticky request, captured in any non-IDLE state.
- It is cleared on entry to IDLE.
- It takes effect only at an instruction boundary (end of WB or jmp EXEC), so no instruction is ever aborted by stop.
- stop in IDLE is ignored. start and stop together in IDLE -> enter FETCH; stop is not captured.

Latency:
- ALU instruction: 4 cycles with zero fetch wait, plus one cycle per fetch-wait cycle.
- jmp: 3 cycles.
- A write-back is visible to the next instruction's DECODE read; no hazard stall is needed because the execution is strictly sequential.

Reset (clr=1 at a clock edge, overrides everything, including mid-instruction):
- state=IDLE, pc=RESET_PC, ir=0, A=B=result=0.
- rf_we=0, rf_wr=0, rf_wdata=0, instr_req=0, busy=0, done=0, stop flag cleared.
- An in-flight write-back is dropped; rf_we must be 0 in the cycle after clr.

Test Plan:
- Single ALU instruction: clr, then start; ROM[0]=8'h4D (addi R3=R0+1) with valid immediate -> rf_we pulses once in cycle 4 with rf_wr=3, rf_wdata=8'h01; pc=1.
- Add and wrap: R1=8'hFF, R2=8'h02, instr 8'h19 (add R1=R1+R2) -> rf_wr=1, rf_wdata=8'h01; then 8'h84 (sub R0=R0-R1) with R0=0 -> rf_wdata=8'hFF.
- Fetch stall: instr_valid held low for 5 cycles in FETCH -> instr_req stays 1, instr_addr stable, no rf_we; the instruction completes 5 cycles later than the zero-wait case.
- Jumps: pc=2 fetches 8'hFF (jmp -1) -> pc=2 again (tight loop, no rf_we); 8'hC0 at pc=5 -> IDLE, done pulses once, pc=6, busy=0.
- Stop mid-instruction: assert stop for 1 cycle during DECODE of an add -> the write-back still occurs, then IDLE with done=1, and no further instr_req.
- Reset mid-WB: clr asserted in the WB cycle -> rf_we=0 in the next cycle, pc=RESET_PC, busy=0, no write observed at the register file.
